gcd_ctrl: RTL

Control FSM for the 8-bit subtractive GCD datapath. It accepts a start request and sequences the operand-select muxes and register loads for A and B. Each cycle it reads the datapath comparator flags, and it reports done, error, the result source and the iteration count. It sits beside the datapath (operand muxes, A/B registers, subtractors, comparator) inside the GCD top level.

---
 rtl/gcd_pkg.sv | 19 +
 rtl/gcd_ctrl.sv | 117 +++++++++++
 2 files changed

// File: rtl/gcd_pkg.sv
// rtl/gcd_pkg.sv - shared widths, state encodings and result-source codes for the GCD controller
package gcd_pkg;

    localparam int WIDTH  = 8;
    localparam int ITER_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_CHECK = 3'd2,
        ST_SUB_A = 3'd3,
        ST_SUB_B = 3'd4,
        ST_DONE  = 3'd5
    } gcd_state_e;

    localparam logic OUT_SEL_A = 1'b0;
    localparam logic OUT_SEL_B = 1'b1;

endpackage

// File: rtl/gcd_ctrl.sv
// rtl/gcd_ctrl.sv - control FSM sequencing the subtractive GCD datapath
module gcd_ctrl #(
    parameter int WIDTH    = 8,
    parameter int MAX_ITER = 255
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic                        a_gt_b,
    input  logic                        a_lt_b,
    input  logic                        a_eq_b,
    input  logic                        a_zero,
    input  logic                        b_zero,
    output logic                        sel_A,
    output logic                        sel_B,
    output logic                        ld_A,
    output logic                        ld_B,
    output logic                        busy,
    output logic                        done,
    output logic                        err,
    output logic                        out_sel,
    output logic [gcd_pkg::ITER_W-1:0]  iter_cnt
);
    import gcd_pkg::*;

    if (WIDTH != gcd_pkg::WIDTH || MAX_ITER < 1 || MAX_ITER > 255) begin : g_param_check
        $error("gcd_ctrl: WIDTH must match gcd_pkg and MAX_ITER must be 1..255");
    end

    localparam logic [ITER_W-1:0] MAX_CNT = ITER_W'(MAX_ITER);

    gcd_state_e              state, state_d;
    logic                    err_d, out_sel_d;
    logic [ITER_W-1:0]       iter_d;

    always_comb begin
        state_d   = state;
        err_d     = err;
        out_sel_d = out_sel;
        iter_d    = iter_cnt;
        sel_A     = 1'b0;
        sel_B     = 1'b0;
        ld_A      = 1'b0;
        ld_B      = 1'b0;
        done      = 1'b0;
        busy      = (state != ST_IDLE);

        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_d   = ST_LOAD;
                    iter_d    = '0;
                    err_d     = 1'b0;
                    out_sel_d = OUT_SEL_A;
                end
            end
            ST_LOAD: begin
                ld_A    = 1'b1;
                ld_B    = 1'b1;
                state_d = ST_CHECK;
            end
            ST_CHECK: begin
                if (a_zero && b_zero) begin
                    err_d     = 1'b1;
                    out_sel_d = OUT_SEL_A;
                    state_d   = ST_DONE;
                end else if (a_zero) begin
                    out_sel_d = OUT_SEL_B;
                    state_d   = ST_DONE;
                end else if (b_zero || a_eq_b) begin
                    out_sel_d = OUT_SEL_A;
                    state_d   = ST_DONE;
                end else if (iter_cnt == MAX_CNT) begin
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                // Contradictory gt+lt flags take the SUB_B default like any other bad flag set.
                end else if (a_gt_b && !a_lt_b) begin
                    state_d = ST_SUB_A;
                end else begin
                    state_d = ST_SUB_B;
                end
            end
            ST_SUB_A: begin
                sel_A   = 1'b1;
                ld_A    = 1'b1;
                iter_d  = iter_cnt + 1'b1;
                state_d = ST_CHECK;
            end
            ST_SUB_B: begin
                sel_B   = 1'b1;
                ld_B    = 1'b1;
                iter_d  = iter_cnt + 1'b1;
                state_d = ST_CHECK;
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            err      <= 1'b0;
            out_sel  <= OUT_SEL_A;
            iter_cnt <= '0;
        end else begin
            state    <= state_d;
            err      <= err_d;
            out_sel  <= out_sel_d;
            iter_cnt <= iter_d;
        end
    end

endmodule
